// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding, widths and latency math for the systolic tile controller
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_DONE
  } ctrl_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold the value max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic int aw_f(input int k_max);
    return (k_max > 1) ? $clog2(k_max) : 1;
  endfunction

  function automatic int kw_f(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int rw_f(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // The last lane starts max(rows,cols)-1 cycles late and then needs k cycles of its own.
  function automatic int feed_cyc(input int k, input int rows, input int cols);
    return k + max2(rows, cols) - 1;
  endfunction

  function automatic int drain_cyc(input int pe_lat, input int acc_lat, input int rows, input int cols);
    return pe_lat * (rows + cols - 2) + acc_lat;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_skew_rd_gen.sv
// rtl/systolic_array_ctrl_skew_rd_gen.sv - per-lane skewed operand-buffer read enable and index
module skew_rd_gen #(
  parameter int FW   = 9,
  parameter int KW   = 9,
  parameter int AW   = 8,
  parameter int LANE = 0
) (
  input  logic          feed_active,
  input  logic [FW-1:0] feed_cnt,
  input  logic [KW-1:0] k_len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr
);

  logic [FW-1:0] diff;
  logic          started;

  // Subtraction is only meaningful once the lane has started, so the >= guard hides any wrap.
  always_comb begin
    started = feed_cnt >= FW'(LANE);
    diff    = feed_cnt - FW'(LANE);
    rd_en   = feed_active && started && (diff < FW'(k_len));
    rd_addr = rd_en ? AW'(diff) : '0;
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - one-tile sequencer: clear, skewed feed, drain, row readout
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter  int ROWS    = 4,
  parameter  int COLS    = 4,
  parameter  int K_MAX   = 256,
  parameter  int PE_LAT  = 2,
  parameter  int ACC_LAT = 3,
  localparam int AW      = aw_f(K_MAX),
  localparam int KW      = kw_f(K_MAX),
  localparam int RW      = rw_f(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               abort,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               aborted,
  output logic               pe_clr,
  output logic [ROWS-1:0]    a_rd_en,
  output logic [ROWS*AW-1:0] a_rd_addr,
  output logic [COLS-1:0]    b_rd_en,
  output logic [COLS*AW-1:0] b_rd_addr,
  output logic               res_valid,
  output logic [RW-1:0]      res_row
);

  localparam int FW   = cnt_w(feed_cyc(K_MAX, ROWS, COLS));
  localparam int DCYC = drain_cyc(PE_LAT, ACC_LAT, ROWS, COLS);
  localparam int DW   = cnt_w(DCYC);

  ctrl_state_t   state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [FW-1:0] feed_cnt_q, feed_cnt_d, feed_last;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [RW-1:0] res_row_q, res_row_d;
  logic          err_flag_q, err_flag_d;
  logic          aborted_q, aborted_d;
  logic          feed_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      res_row_q   <= '0;
      err_flag_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      res_row_q   <= res_row_d;
      err_flag_q  <= err_flag_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    feed_cnt_d  = feed_cnt_q;
    drain_cnt_d = drain_cnt_q;
    res_row_d   = res_row_q;
    err_flag_d  = err_flag_q;
    aborted_d   = 1'b0;
    feed_last   = FW'(feed_cyc(int'(k_len_q), ROWS, COLS) - 1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len == '0 || k_len > KW'(K_MAX)) begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            k_len_d = k_len;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        feed_cnt_d = '0;
        state_d    = S_FEED;
      end
      S_FEED: begin
        if (feed_cnt_q == feed_last) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          feed_cnt_d = feed_cnt_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DCYC - 1)) begin
          res_row_d = '0;
          state_d   = S_READ;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_READ: begin
        if (res_ready) begin
          if (res_row_q == RW'(ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            res_row_d = res_row_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        err_flag_d = 1'b0;
        res_row_d  = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition, including the final READ handshake.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      err_flag_d = 1'b0;
      res_row_d  = '0;
      aborted_d  = 1'b1;
    end
  end

  assign feed_active = (state_q == S_FEED);

  for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
    skew_rd_gen #(.FW(FW), .KW(KW), .AW(AW), .LANE(r)) u_skew (
      .feed_active(feed_active),
      .feed_cnt   (feed_cnt_q),
      .k_len      (k_len_q),
      .rd_en      (a_rd_en[r]),
      .rd_addr    (a_rd_addr[r*AW +: AW])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_lane
    skew_rd_gen #(.FW(FW), .KW(KW), .AW(AW), .LANE(c)) u_skew (
      .feed_active(feed_active),
      .feed_cnt   (feed_cnt_q),
      .k_len      (k_len_q),
      .rd_en      (b_rd_en[c]),
      .rd_addr    (b_rd_addr[c*AW +: AW])
    );
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_flag_q;
  assign aborted   = aborted_q;
  assign pe_clr    = (state_q == S_CLEAR);
  assign res_valid = (state_q == S_READ);
  assign res_row   = res_row_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed scoreboard bench for systolic_array_ctrl
module tb_systolic_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int AW   = 8;
  localparam int KW   = 9;
  localparam int RW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               abort = 1'b0;
  logic               res_ready = 1'b1;
  logic               busy, done, err, aborted, pe_clr, res_valid;
  logic [ROWS-1:0]    a_rd_en;
  logic [ROWS*AW-1:0] a_rd_addr;
  logic [COLS-1:0]    b_rd_en;
  logic [COLS*AW-1:0] b_rd_addr;
  logic [RW-1:0]      res_row;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int exp_rows[$];
  int exp_err[$];

  systolic_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .res_ready(res_ready), .busy(busy), .done(done), .err(err), .aborted(aborted),
    .pe_clr(pe_clr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en),
    .b_rd_addr(b_rd_addr), .res_valid(res_valid), .res_row(res_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int k);
    k_len = KW'(k);
    start = 1'b1;
    if (k >= 1 && k <= 256) begin
      for (int r = 0; r < ROWS; r++) exp_rows.push_back(r);
      exp_err.push_back(0);
    end else begin
      exp_err.push_back(1);
    end
    step();
    start = 1'b0;
    k_len = '1;
  endtask

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (res_valid && res_ready) begin
        hs_cnt++;
        chk("handshake_expected", exp_rows.size() > 0, 1);
        if (exp_rows.size() > 0) begin
          e = exp_rows.pop_front();
          chk("res_row", res_row, e);
        end
      end
      if (done) begin
        chk("done_expected", exp_err.size() > 0, 1);
        if (exp_err.size() > 0) begin
          e = exp_err.pop_front();
          chk("err_on_done", err, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_feed;
    logic saw_done;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_pe_clr", pe_clr, 0);
    chk("rst_a_en", a_rd_en, 0);
    chk("rst_a_addr", a_rd_addr, 0);
    chk("rst_b_en", b_rd_en, 0);
    chk("rst_b_addr", b_rd_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_row", res_row, 0);
    rst = 1'b0;
    step();

    // Nominal k=4 tile; loop index c is the cycle number after start (start in cycle 0).
    hs_cnt = 0;
    start_tile(4);
    for (int c = 1; c <= 30; c++) begin
      int f;
      logic [ROWS-1:0] ea;
      logic [ROWS*AW-1:0] eaddr;
      f = c - 2;
      ea = '0;
      eaddr = '0;
      if (c >= 2 && c <= 8) begin
        for (int r = 0; r < ROWS; r++) begin
          if (f >= r && f - r < 4) begin
            ea[r] = 1'b1;
            eaddr[r*AW +: AW] = AW'(f - r);
          end
        end
      end
      chk("nom_busy", busy, c <= 28);
      chk("nom_pe_clr", pe_clr, c == 1);
      chk("nom_res_valid", res_valid, c >= 24 && c <= 27);
      chk("nom_done", done, c == 28);
      chk("nom_err", err, 0);
      chk("nom_a_en", a_rd_en, ea);
      chk("nom_a_addr", a_rd_addr, eaddr);
      chk("nom_b_en", b_rd_en, ea);
      chk("nom_b_addr", b_rd_addr, eaddr);
      if (c == 2) begin
        chk("skew_f0_en", a_rd_en, 4'b0001);
        chk("skew_f0_addr", a_rd_addr, 32'h0000_0000);
      end
      if (c == 5) begin
        chk("skew_f3_en", a_rd_en, 4'b1111);
        chk("skew_f3_addr", a_rd_addr, 32'h0001_0203);
        chk("skew_f3_b_addr", b_rd_addr, 32'h0001_0203);
      end
      if (c == 8) begin
        chk("skew_f6_en", a_rd_en, 4'b1000);
        chk("skew_f6_addr", a_rd_addr, 32'h0300_0000);
        chk("skew_f6_b_en", b_rd_en, 4'b1000);
      end
      step();
    end
    chk("nom_handshakes", hs_cnt, 4);

    // Backpressure on row 1, with an ignored start pulse while busy.
    hs_cnt = 0;
    start_tile(2);
    step();
    start = 1'b1;
    k_len = 3;
    step();
    start = 1'b0;
    n = 0;
    while (!(res_valid && res_row == 1) && n < 100) begin
      step();
      n++;
    end
    chk("bp_reach_row1", n < 100, 1);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_row", res_row, 1);
      chk("bp_hold_valid", res_valid, 1);
      step();
    end
    res_ready = 1'b1;
    chk("bp_row1", res_row, 1);
    step();
    chk("bp_row2", res_row, 2);
    step();
    chk("bp_row3", res_row, 3);
    chk("bp_no_early_done", done, 0);
    step();
    chk("bp_done", done, 1);
    chk("bp_handshakes", hs_cnt, 4);
    step();
    chk("bp_idle", busy, 0);
    repeat (40) step();
    chk("bp_no_extra_tile", busy, 0);
    chk("bp_rows_drained", exp_rows.size(), 0);

    // Illegal lengths finish immediately with err and no array activity.
    for (int i = 0; i < 2; i++) begin
      start_tile(i == 0 ? 0 : 257);
      chk("ill_done", done, 1);
      chk("ill_err", err, 1);
      chk("ill_pe_clr", pe_clr, 0);
      chk("ill_a_en", a_rd_en, 0);
      chk("ill_b_en", b_rd_en, 0);
      chk("ill_res_valid", res_valid, 0);
      step();
      chk("ill_idle", busy, 0);
      chk("ill_done_clear", done, 0);
      chk("ill_err_clear", err, 0);
    end

    // Abort in DRAIN at cycle 15.
    start_tile(4);
    repeat (14) step();
    abort = 1'b1;
    chk("ab_busy_before", busy, 1);
    chk("ab_in_drain", a_rd_en | {3'b0, res_valid}, 0);
    step();
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_pulse", aborted, 1);
    chk("ab_no_done", done, 0);
    chk("ab_res_valid", res_valid, 0);
    exp_rows.delete();
    exp_err.delete();
    step();
    chk("ab_pulse_end", aborted, 0);

    start_tile(1);
    n_feed = 0;
    saw_done = 1'b0;
    n = 0;
    while (!saw_done && n < 100) begin
      if (a_rd_en != 0) n_feed++;
      if (done) saw_done = 1'b1;
      step();
      n++;
    end
    chk("k1_done_seen", saw_done, 1);
    chk("k1_feed_cycles", n_feed, 4);

    // Reset while in READ, after a start pulsed mid-tile.
    start_tile(3);
    res_ready = 1'b0;
    step();
    start = 1'b1;
    k_len = 2;
    step();
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
    end
    chk("rr_reach_read", n < 100, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_res_valid", res_valid, 0);
    chk("rr_done", done, 0);
    chk("rr_a_en", a_rd_en, 0);
    exp_rows.delete();
    exp_err.delete();
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (40) step();
    chk("rr_no_extra_tile", busy, 0);
    chk("rr_done_queue", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
